mfe_img_host: RTL and testbench

//  Host-side responder for the median-filter engine's image interface: owns the grayscale

---
 rtl/mfe_img_host.sv | 180 ++++++++++++++++++
 tb/tb_mfe_img_host.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfe_img_host.sv
// mfe_img_host: host-side image/result memory responder for the median-filter engine.
// Latency: idata/data_rd one cycle after iaddr/addr; first dump beat one cycle after DUMP entry.
// Backpressure: load stream gated by load_ready; dump beat held stable until out_ready.
module mfe_img_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_wr,
  input  logic          wen,
  output logic [DW-1:0] data_rd,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done,
  output logic          wr_err
);

  localparam int N     = IMG_W * IMG_H;
  localparam int DEPTH = 1 << AW;
  // One extra counter bit so a full 2**AW frame still reaches its terminal compare.
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DUMP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0] img_mem [DEPTH];
  logic [DW-1:0] res_mem [DEPTH];

  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] rd_cnt;
  logic          busy_q;

  logic load_beat;
  logic addr_ok;
  logic res_we;
  logic out_accept;
  logic dump_fetch;

  // Qualified strobes shared by the datapath blocks below.
  always_comb begin
    load_beat  = !reset && (state == S_LOAD) && load_valid;
    addr_ok    = ({1'b0, addr} < N_CNT);
    res_we     = !reset && (state == S_RUN) && wen && addr_ok;
    out_accept = out_valid && out_ready;
    // Fetch the next result pixel when the output register is empty, or when the
    // current beat is leaving and it is not the final one.
    dump_fetch = (state == S_DUMP) && (!out_valid || (out_ready && !out_last));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the state-decoded handshakes towards source and engine.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    ready      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (ld_cnt == LAST_IDX)) state_nxt = S_ARM;
      end
      S_ARM: begin
        ready = 1'b1;
        if (busy) state_nxt = S_RUN;
      end
      S_RUN: begin
        // Engine signals completion with a falling edge on busy.
        if (busy_q && !busy) state_nxt = S_DUMP;
      end
      S_DUMP: begin
        if (out_accept && out_last) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Load and dump pixel counters; both restart from zero whenever the block is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt <= '0;
      rd_cnt <= '0;
    end else if (state == S_IDLE) begin
      ld_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (load_beat)  ld_cnt <= ld_cnt + CW'(1);
      if (dump_fetch) rd_cnt <= rd_cnt + CW'(1);
    end
  end

  // Image memory write port, fed by the load stream.
  always_ff @(posedge clk) begin
    if (load_beat) img_mem[ld_cnt[AW-1:0]] <= load_data;
  end

  // Result memory write port; out-of-range or out-of-phase writes are dropped.
  always_ff @(posedge clk) begin
    if (res_we) res_mem[addr] <= data_wr;
  end

  // Engine read ports: registered every cycle, read-before-write on the result memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      idata   <= '0;
      data_rd <= '0;
    end else begin
      idata   <= img_mem[iaddr];
      data_rd <= res_mem[addr];
    end
  end

  // Busy edge history and the sticky write-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      busy_q <= busy;
      if (wen && ((state != S_RUN) || !addr_ok)) wr_err <= 1'b1;
    end
  end

  // Result stream output register with hold-until-accepted behaviour and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (dump_fetch) begin
        out_valid <= 1'b1;
        out_data  <= res_mem[rd_cnt[AW-1:0]];
        out_last  <= (rd_cnt == LAST_IDX);
      end else if (out_accept && out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mfe_img_host.sv
// Bench for mfe_img_host: a full-size instance and a small 16x15 instance driven in turn.
// A frame-level model tracks the expected mode, memory images and dump progress.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mfe_img_host;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_ARM  = 2;
  localparam int P_RUN  = 3;
  localparam int P_DUMP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [2];
  logic          start      [2];
  logic          load_valid [2];
  logic [DW-1:0] load_data  [2];
  logic          load_ready [2];
  logic          ready      [2];
  logic          busy       [2];
  logic [AW-1:0] iaddr      [2];
  logic [DW-1:0] idata      [2];
  logic [AW-1:0] addr       [2];
  logic [DW-1:0] data_wr    [2];
  logic          wen        [2];
  logic [DW-1:0] data_rd    [2];
  logic          out_valid  [2];
  logic [DW-1:0] out_data   [2];
  logic          out_last   [2];
  logic          out_ready  [2];
  logic          done       [2];
  logic          wr_err     [2];

  mfe_img_host u_big (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .load_valid(load_valid[0]), .load_data(load_data[0]), .load_ready(load_ready[0]),
    .ready(ready[0]), .busy(busy[0]), .iaddr(iaddr[0]), .idata(idata[0]),
    .addr(addr[0]), .data_wr(data_wr[0]), .wen(wen[0]), .data_rd(data_rd[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .out_ready(out_ready[0]), .done(done[0]), .wr_err(wr_err[0])
  );

  mfe_img_host #(.IMG_W(16), .IMG_H(15), .AW(AW), .DW(DW)) u_small (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .load_valid(load_valid[1]), .load_data(load_data[1]), .load_ready(load_ready[1]),
    .ready(ready[1]), .busy(busy[1]), .iaddr(iaddr[1]), .idata(idata[1]),
    .addr(addr[1]), .data_wr(data_wr[1]), .wen(wen[1]), .data_rd(data_rd[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .out_ready(out_ready[1]), .done(done[1]), .wr_err(wr_err[1])
  );

  // ---------------- behavioural model ----------------
  int            n_pix [2] = '{16384, 240};
  int            phase [2];
  int            ld_idx [2];
  int            beat_idx [2];
  int            dump_age [2];
  int            beats_acc [2];
  int            done_cnt [2];
  logic [DW-1:0] img_m [2][DEPTH];
  logic [DW-1:0] res_m [2][DEPTH];
  bit            img_k [2][DEPTH];
  bit            res_k [2][DEPTH];
  logic [DW-1:0] e_idata [2];
  logic [DW-1:0] e_drd [2];
  bit            e_idata_k [2];
  bit            e_drd_k [2];
  bit            e_wr_err [2];
  bit            e_done [2];
  bit            busy_prev [2];
  bit            live [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from the inputs presented at that edge.
  task automatic model_step(input int d);
    int a;
    int ia;
    if (rst[d] === 1'b1) begin
      phase[d] = P_IDLE; ld_idx[d] = 0; beat_idx[d] = 0; dump_age[d] = 0;
      e_idata[d] = '0; e_drd[d] = '0; e_idata_k[d] = 1'b1; e_drd_k[d] = 1'b1;
      e_wr_err[d] = 1'b0; e_done[d] = 1'b0; busy_prev[d] = 1'b0; live[d] = 1'b1;
    end else if (live[d]) begin
      ia = int'(iaddr[d]);
      a  = int'(addr[d]);
      e_idata[d] = img_m[d][ia]; e_idata_k[d] = img_k[d][ia];
      e_drd[d]   = res_m[d][a];  e_drd_k[d]   = res_k[d][a];
      e_done[d]  = 1'b0;
      if (wen[d]) begin
        if (phase[d] == P_RUN && a < n_pix[d]) begin
          res_m[d][a] = data_wr[d];
          res_k[d][a] = 1'b1;
        end else begin
          e_wr_err[d] = 1'b1;
        end
      end
      case (phase[d])
        P_IDLE: if (start[d]) begin phase[d] = P_LOAD; ld_idx[d] = 0; end
        P_LOAD: if (load_valid[d]) begin
          img_m[d][ld_idx[d]] = load_data[d];
          img_k[d][ld_idx[d]] = 1'b1;
          ld_idx[d]++;
          if (ld_idx[d] == n_pix[d]) phase[d] = P_ARM;
        end
        P_ARM: if (busy[d]) phase[d] = P_RUN;
        P_RUN: if (busy_prev[d] && !busy[d]) begin
          phase[d] = P_DUMP; beat_idx[d] = 0; dump_age[d] = 0;
        end
        P_DUMP: begin
          if (dump_age[d] >= 1 && out_ready[d]) begin
            beats_acc[d]++;
            if (beat_idx[d] == n_pix[d] - 1) begin
              e_done[d] = 1'b1; done_cnt[d]++; phase[d] = P_IDLE;
            end else begin
              beat_idx[d]++;
            end
          end
          dump_age[d]++;
        end
        default: ;
      endcase
      busy_prev[d] = busy[d];
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Compare every meaningful DUT output against the model.
  task automatic compare_dut(input int d);
    bit ev;
    ev = (phase[d] == P_DUMP) && (dump_age[d] >= 1);
    chk("load_ready", d, 32'(load_ready[d]), 32'(phase[d] == P_LOAD));
    chk("ready", d, 32'(ready[d]), 32'(phase[d] == P_ARM));
    chk("wr_err", d, 32'(wr_err[d]), 32'(e_wr_err[d]));
    chk("done", d, 32'(done[d]), 32'(e_done[d]));
    chk("out_valid", d, 32'(out_valid[d]), 32'(ev));
    if (e_idata_k[d]) chk("idata", d, 32'(idata[d]), 32'(e_idata[d]));
    if (e_drd_k[d]) chk("data_rd", d, 32'(data_rd[d]), 32'(e_drd[d]));
    if (ev) begin
      chk("out_last", d, 32'(out_last[d]), 32'(beat_idx[d] == n_pix[d] - 1));
      if (res_k[d][beat_idx[d]]) chk("out_data", d, 32'(out_data[d]), 32'(res_m[d][beat_idx[d]]));
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) if (live[d]) compare_dut(d);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    start[d] = 1'b0; load_valid[d] = 1'b0; load_data[d] = '0; busy[d] = 1'b0;
    iaddr[d] = '0; addr[d] = '0; data_wr[d] = '0; wen[d] = 1'b0; out_ready[d] = 1'b0;
  endtask

  task automatic load_frame(input int d, input bit seq, input bit gaps);
    int k;
    int cyc;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    k = 0;
    cyc = 0;
    while (k < n_pix[d] && cyc < 4 * n_pix[d]) begin
      load_valid[d] = gaps ? ($urandom_range(3) != 0) : 1'b1;
      load_data[d]  = seq ? k[7:0] : 8'($urandom);
      tick();
      if (load_valid[d]) k++;
      cyc++;
    end
    load_valid[d] = 1'b0;
    chk("load_beats", d, k, n_pix[d]);
    chk("load_ready_low_after_last", d, 32'(load_ready[d]), 32'd0);
    chk("ready_after_load", d, 32'(ready[d]), 32'd1);
  endtask

  task automatic arm_run(input int d, input int hold);
    busy[d] = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    chk("ready_held_in_arm", d, 32'(ready[d]), 32'd1);
    busy[d] = 1'b1;
    tick();
    chk("ready_drop_on_busy", d, 32'(ready[d]), 32'd0);
  endtask

  task automatic run_phase(input int d, input bit bad_addr);
    logic [DW-1:0] old5;
    old5 = '0;
    if (d == 0) begin
      iaddr[0] = AW'(129);
      tick();
      chk("idata_at_129", 0, 32'(idata[0]), 32'h81);
    end
    for (int a = 0; a < n_pix[d]; a++) begin
      addr[d]    = AW'(a);
      wen[d]     = 1'b1;
      data_wr[d] = 8'($urandom);
      if (a == 5) old5 = data_wr[d];
      iaddr[d]   = AW'($urandom_range(n_pix[d] - 1));
      if (d == 1) start[d] = ($urandom_range(7) == 0);
      tick();
    end
    start[d]   = 1'b0;
    addr[d]    = AW'(5);
    data_wr[d] = 8'h3C;
    tick();
    wen[d] = 1'b0;
    chk("rd_before_write", d, 32'(data_rd[d]), 32'(old5));
    tick();
    chk("rd_after_write", d, 32'(data_rd[d]), 32'h3C);
    if (bad_addr) begin
      addr[d]    = AW'(n_pix[d] + int'($urandom_range(15)));
      data_wr[d] = 8'($urandom);
      wen[d]     = 1'b1;
      tick();
      wen[d] = 1'b0;
      chk("wr_err_addr_range", d, 32'(wr_err[d]), 32'd1);
    end
  endtask

  task automatic dump_frame(input int d, input bit toggle, input int abort_at);
    int cyc;
    int d0;
    d0 = done_cnt[d];
    beats_acc[d] = 0;
    cyc = 0;
    busy[d] = 1'b0;
    tick();
    while (done_cnt[d] == d0 && cyc < 4 * n_pix[d] + 16 &&
           !(abort_at >= 0 && beats_acc[d] >= abort_at)) begin
      out_ready[d] = toggle ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
      tick();
      cyc++;
    end
    out_ready[d] = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_beat_count", d, beats_acc[d], abort_at);
      rst[d] = 1'b1;
      tick();
      rst[d] = 1'b0;
      chk("abort_out_valid", d, 32'(out_valid[d]), 32'd0);
      chk("abort_load_ready", d, 32'(load_ready[d]), 32'd0);
      chk("abort_wr_err_cleared", d, 32'(wr_err[d]), 32'd0);
    end else begin
      chk("done_count", d, done_cnt[d] - d0, 1);
      chk("beats_accepted", d, beats_acc[d], n_pix[d]);
      chk("done_pulse_high", d, 32'(done[d]), 32'd1);
      tick();
      chk("done_pulse_low", d, 32'(done[d]), 32'd0);
      chk("out_valid_after_done", d, 32'(out_valid[d]), 32'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] saved;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      idle_inputs(d);
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_load_ready", d, 32'(load_ready[d]), 32'd0);
      chk("rst_ready", d, 32'(ready[d]), 32'd0);
      chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
      chk("rst_out_last", d, 32'(out_last[d]), 32'd0);
      chk("rst_done", d, 32'(done[d]), 32'd0);
      chk("rst_wr_err", d, 32'(wr_err[d]), 32'd0);
      chk("rst_idata", d, 32'(idata[d]), 32'd0);
      chk("rst_data_rd", d, 32'(data_rd[d]), 32'd0);
      chk("rst_out_data", d, 32'(out_data[d]), 32'd0);
      rst[d] = 1'b0;
    end
    tick();

    // Full-size frame: sequential pixel data, toggling sink.
    load_frame(0, 1'b1, 1'b0);
    arm_run(0, 10);
    run_phase(0, 1'b0);
    dump_frame(0, 1'b1, -1);

    // Small frame with an out-of-range write, aborted by reset at beat 100.
    load_frame(1, 1'b0, 1'b1);
    arm_run(1, 3);
    run_phase(1, 1'b1);
    dump_frame(1, 1'b0, 100);

    // Fresh small frame after the abort, run to completion.
    tick();
    load_frame(1, 1'b0, 1'b1);
    arm_run(1, 2);
    run_phase(1, 1'b0);
    dump_frame(1, 1'b0, -1);
    chk("wr_err_clean_frame", 1, 32'(wr_err[1]), 32'd0);

    // Write attempt while idle: flagged, dropped, and the flag is sticky.
    saved      = res_m[1][3];
    addr[1]    = AW'(3);
    data_wr[1] = ~saved;
    wen[1]     = 1'b1;
    tick();
    wen[1] = 1'b0;
    chk("wr_err_idle_write", 1, 32'(wr_err[1]), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("wr_err_sticky", 1, 32'(wr_err[1]), 32'd1);
    chk("idle_write_dropped", 1, 32'(data_rd[1]), 32'(saved));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
